// File: rtl/wl_regd_pipe.sv
// ---------------------------------------------------------------------------
// wl_regd_pipe
//
// Elastic register pipeline of DEPTH stages, each DW bits wide with its own
// valid bit. Stages hand data forward under valid/ready handshaking; an empty
// stage always accepts, so bubbles collapse even while the output is stalled.
// DEPTH = 0 degenerates to a purely combinational pass-through.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high (priority over flush)
//   flush      synchronous pipeline clear, active-high
//   in_valid   upstream beat valid
//   in_ready   pipeline accepts in_data this cycle
//   in_data    upstream beat data [DW-1:0]
//   out_valid  out_data holds a valid beat
//   out_ready  downstream accepts out_data this cycle
//   out_data   last-stage data [DW-1:0]
//   count      number of stages currently holding a valid beat [CW-1:0]
// ---------------------------------------------------------------------------
module wl_regd_pipe #(
  parameter int DW       = 8,
  parameter int DEPTH    = 2,
  parameter int RST_DATA = 1,
  parameter int CW       = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] count
);

  if (DEPTH == 0) begin : gPass

    // No storage at all: handshake and data go straight through, and the
    // clock and clear inputs are deliberately ignored.
    logic w_unused;

    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign count     = '0;
    assign w_unused  = ^{clk, rst, flush};

  end else begin : gPipe

    logic [DEPTH-1:0]         r_valid;
    logic [DEPTH-1:0][DW-1:0] r_data;
    logic [CW-1:0]            r_count;

    logic [DEPTH:0]           w_accept;
    logic [DEPTH-1:0]         w_prevValid;
    logic [DEPTH-1:0][DW-1:0] w_prevData;
    logic                     w_clear;
    logic                     w_inXfer;
    logic                     w_outXfer;

    // Ready chain, computed from the output side backwards: a stage can take
    // a new beat if it is empty or if the stage after it is moving too. This
    // is deliberately combinational end to end so a full pipe can accept and
    // deliver in the same cycle.
    always_comb begin
      w_accept        = '0;
      w_accept[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        w_accept[i] = ~r_valid[i] | w_accept[i+1];
      end
    end

    // What each stage would load: stage 0 looks at the upstream port, every
    // other stage at its predecessor.
    always_comb begin
      w_prevValid    = '0;
      w_prevData     = '0;
      w_prevValid[0] = in_valid;
      w_prevData[0]  = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        w_prevValid[i] = r_valid[i-1];
        w_prevData[i]  = r_data[i-1];
      end
    end

    // rst and flush have identical register effect; both also mask the
    // handshake outputs so nothing is accepted or delivered in that cycle.
    assign w_clear   = rst | flush;
    assign in_ready  = w_accept[0] & ~w_clear;
    assign out_valid = r_valid[DEPTH-1] & ~w_clear;
    assign out_data  = r_data[DEPTH-1];
    assign count     = r_count;

    assign w_inXfer  = in_valid & in_ready;
    assign w_outXfer = out_valid & out_ready;

    // Valid bits always clear; an accepting stage copies its predecessor's
    // valid, which is how a bubble moves forward and gets squeezed out.
    always_ff @(posedge clk) begin
      if (w_clear) begin
        r_valid <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_accept[i]) begin
            r_valid[i] <= w_prevValid[i];
          end
        end
      end
    end

    // Data only moves when a real beat arrives, so an emptied stage keeps its
    // last value instead of toggling on bubbles. Clearing the data is
    // optional; with RST_DATA = 0 the data path carries no reset at all.
    always_ff @(posedge clk) begin
      if ((RST_DATA != 0) && w_clear) begin
        r_data <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_accept[i] && w_prevValid[i]) begin
            r_data[i] <= w_prevData[i];
          end
        end
      end
    end

    // Occupancy tracks the port handshakes rather than summing valid bits;
    // simultaneous in and out transfers cancel.
    always_ff @(posedge clk) begin
      if (w_clear) begin
        r_count <= '0;
      end else if (w_inXfer && !w_outXfer) begin
        r_count <= r_count + CW'(1);
      end else if (!w_inXfer && w_outXfer) begin
        r_count <= r_count - CW'(1);
      end
    end

  end

endmodule

// File: tb/tb_wl_regd_pipe.sv
`timescale 1ns/1ps
module tb_wl_regd_pipe;

   localparam int NI = 6;

   // Instance depths: 0..2 carry the directed scenarios, 3..5 the random run.
   function automatic int depthOf(input int g);
      case (g)
         0:       return 3;
         1:       return 4;
         2:       return 2;
         3:       return 0;
         4:       return 1;
         default: return 5;
      endcase
   endfunction

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       inValid  [NI];
   logic       inReady  [NI];
   logic [7:0] inData   [NI];
   logic       outValid [NI];
   logic       outReady [NI];
   logic [7:0] outData  [NI];
   logic       flushSig [NI];
   logic [3:0] count    [NI];

   int testsRun    = 0;
   int testsFailed = 0;
   int nextIdx;
   logic [7:0] latBeats [3];

   always #5 clock = ~clock;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive one cycle's worth of inputs on one instance, just after the edge.
   task automatic applyStimulus(input int g, input logic v, input logic [7:0] d, input logic r, input logic f);
      @(posedge clock);
      #1;
      inValid[g]  = v;
      inData[g]   = d;
      outReady[g] = r;
      flushSig[g] = f;
   endtask

   // One DUT per depth, each with its own scoreboard. The monitor runs on the
   // falling edge, seeing the inputs and state that the next rising edge acts on.
   for (genvar g = 0; g < NI; g++) begin : gInst
      logic [7:0] sbq [$];

      wl_regd_pipe #(.DW(8), .DEPTH(depthOf(g)), .RST_DATA(1), .CW(4)) dut (
         .clk       (clock),
         .rst       (reset),
         .flush     (flushSig[g]),
         .in_valid  (inValid[g]),
         .in_ready  (inReady[g]),
         .in_data   (inData[g]),
         .out_valid (outValid[g]),
         .out_ready (outReady[g]),
         .out_data  (outData[g]),
         .count     (count[g])
      );

      always @(negedge clock) begin
         if (reset) begin
            sbq.delete();
         end else begin
            checkOutput($sformatf("count%0d", g), 32'(count[g]), 32'(sbq.size()));
            if (inValid[g] && inReady[g]) begin
               sbq.push_back(inData[g]);
            end
            if (outValid[g] && outReady[g]) begin
               if (sbq.size() == 0) begin
                  checkOutput($sformatf("underflow%0d", g), 32'(sbq.size()), 1);
               end else begin
                  checkOutput($sformatf("data%0d", g), 32'(outData[g]), 32'(sbq.pop_front()));
               end
            end
            if (flushSig[g]) begin
               sbq.delete();
            end
         end
      end
   end

   // Hard time limit so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int g = 0; g < NI; g++) begin
         inValid[g]  = 1'b0;
         inData[g]   = 8'h00;
         outReady[g] = 1'b1;
         flushSig[g] = 1'b0;
      end
      latBeats[0] = 8'h11;
      latBeats[1] = 8'h22;
      latBeats[2] = 8'h33;

      // Reset: two edges with reset high, handshakes masked meanwhile.
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("rstInReady", 32'(inReady[0]), 0);
      checkOutput("rstOutValid", 32'(outValid[0]), 0);
      reset = 1'b0;
      #1;
      for (int g = 0; g < 3; g++) begin
         checkOutput($sformatf("postRstOutValid%0d", g), 32'(outValid[g]), 0);
         checkOutput($sformatf("postRstOutData%0d", g), 32'(outData[g]), 0);
         checkOutput($sformatf("postRstCount%0d", g), 32'(count[g]), 0);
         checkOutput($sformatf("postRstInReady%0d", g), 32'(inReady[g]), 1);
      end

      // Latency on DEPTH=3: a beat taken at one edge is presented three
      // cycles later.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, (i < 3) ? 1'b1 : 1'b0, (i < 3) ? latBeats[i] : 8'h00, 1'b1, 1'b0);
         #1;
         if (i < 3) begin
            checkOutput("latEarly", 32'(outValid[0]), 0);
         end else begin
            checkOutput("latValid", 32'(outValid[0]), 1);
            checkOutput("latData", 32'(outData[0]), 32'(latBeats[i-3]));
         end
         if (i == 3) checkOutput("latCountPeak", 32'(count[0]), 3);
      end
      repeat (3) applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("latDrained", 32'(gInst[0].sbq.size()), 0);

      // Stall on DEPTH=3: offer A0.. continuously with the output blocked.
      nextIdx = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1'b1, 8'hA0 + 8'(nextIdx), 1'b0, 1'b0);
         #1;
         if (inReady[0]) nextIdx++;
      end
      applyStimulus(0, 1'b1, 8'hA0 + 8'(nextIdx), 1'b0, 1'b0);
      #1;
      checkOutput("stallAccepted", 32'(nextIdx), 3);
      checkOutput("stallInReady", 32'(inReady[0]), 0);
      checkOutput("stallCount", 32'(count[0]), 3);
      checkOutput("stallOutValid", 32'(outValid[0]), 1);
      checkOutput("stallHead", 32'(outData[0]), 32'h0A0);
      for (int i = 0; i < 20 && nextIdx < 5; i++) begin
         applyStimulus(0, 1'b1, 8'hA0 + 8'(nextIdx), 1'b1, 1'b0);
         #1;
         if (inReady[0]) nextIdx++;
      end
      checkOutput("stallAllSent", 32'(nextIdx), 5);
      repeat (6) applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("stallDrained", 32'(gInst[0].sbq.size()), 0);

      // Bubble collapse on DEPTH=4 with the output blocked.
      applyStimulus(1, 1'b1, 8'h5A, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1, 1'b1, 8'h5B, 1'b0, 1'b0);
      repeat (3) applyStimulus(1, 1'b0, 8'h00, 1'b0, 1'b0);
      #1;
      checkOutput("bubbleCount", 32'(count[1]), 2);
      checkOutput("bubbleInReady", 32'(inReady[1]), 1);
      checkOutput("bubbleOutValid", 32'(outValid[1]), 1);
      checkOutput("bubbleHead", 32'(outData[1]), 32'h05A);
      repeat (6) applyStimulus(1, 1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("bubbleDrained", 32'(gInst[1].sbq.size()), 0);

      // Flush on a full DEPTH=2 pipe while 0xFF is offered.
      applyStimulus(2, 1'b1, 8'h01, 1'b0, 1'b0);
      applyStimulus(2, 1'b1, 8'h02, 1'b0, 1'b0);
      applyStimulus(2, 1'b1, 8'hFF, 1'b1, 1'b1);
      #1;
      checkOutput("flushFullCount", 32'(count[2]), 2);
      checkOutput("flushInReady", 32'(inReady[2]), 0);
      checkOutput("flushOutValid", 32'(outValid[2]), 0);
      applyStimulus(2, 1'b0, 8'h00, 1'b1, 1'b0);
      #1;
      checkOutput("afterFlushCount", 32'(count[2]), 0);
      checkOutput("afterFlushOutValid", 32'(outValid[2]), 0);
      checkOutput("afterFlushInReady", 32'(inReady[2]), 1);
      repeat (4) applyStimulus(2, 1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("flushDrained", 32'(gInst[2].sbq.size()), 0);

      // Random traffic on DEPTH 0, 1 and 5 at once; the monitors do the checking.
      for (int c = 0; c < 10000; c++) begin
         @(posedge clock);
         #1;
         for (int g = 3; g < NI; g++) begin
            inValid[g]  = 1'($urandom_range(0, 1));
            outReady[g] = 1'($urandom_range(0, 1));
            inData[g]   = 8'($urandom);
         end
      end
      @(posedge clock);
      #1;
      for (int g = 3; g < NI; g++) begin
         inValid[g]  = 1'b0;
         outReady[g] = 1'b1;
      end
      repeat (10) @(posedge clock);
      #1;
      checkOutput("randDrained3", 32'(gInst[3].sbq.size()), 0);
      checkOutput("randDrained4", 32'(gInst[4].sbq.size()), 0);
      checkOutput("randDrained5", 32'(gInst[5].sbq.size()), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
